// File: rtl/wb_byte_master_pkg.sv
// Shared constants and state encoding for the UART-driven Wishbone master.
// Command/response bytes match the host-side tool protocol.
package wb_byte_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP,
    S_RDATA
  } state_t;

endpackage

// File: rtl/wb_byte_timeout.sv
// Saturating cycle timer; expired is high during the N-th enabled cycle
// since the last clear, so the owner acts exactly N cycles after clear.
module wb_byte_timeout #(
  parameter int N = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] MAX  = W'(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/wb_byte_master.sv
// Byte-stream command parser that runs one classic Wishbone cycle per
// frame and streams a status (and read data) back to the transmitter.
module wb_byte_master
  import wb_byte_master_pkg::*;
#(
  parameter int BUS_TIMEOUT  = 255,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  state_t      state;
  logic [1:0]  bcnt;
  logic [31:0] rsh;
  logic        ok;
  logic        in_field;
  logic        bus_exp;
  logic        idle_exp;

  assign in_field  = (state == S_ADDR) || (state == S_WDATA);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_sel_o = 4'hF;
  assign busy      = (state != S_IDLE);

  wb_byte_timeout #(.N(BUS_TIMEOUT)) u_bus_tmr (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (state != S_BUS),
    .enable  (state == S_BUS),
    .expired (bus_exp)
  );

  wb_byte_timeout #(.N(IDLE_TIMEOUT)) u_idle_tmr (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (rx_valid || !in_field),
    .enable  (in_field),
    .expired (idle_exp)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      bcnt      <= 2'd0;
      rsh       <= 32'd0;
      ok        <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
            wbm_we_o <= (rx_data == CMD_WR);
            bcnt     <= 2'd0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
            bcnt      <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state     <= wbm_we_o ? S_WDATA : S_BUS;
              wbm_cyc_o <= !wbm_we_o;
            end
          end else if (idle_exp) begin
            bcnt  <= 2'd0;
            state <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            wbm_dat_o <= {wbm_dat_o[23:0], rx_data};
            bcnt      <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state     <= S_BUS;
              wbm_cyc_o <= 1'b1;
            end
          end else if (idle_exp) begin
            bcnt  <= 2'd0;
            state <= S_IDLE;
          end
        end
        S_BUS: begin
          // ack takes priority over a timeout landing in the same cycle
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            ok        <= 1'b1;
            if (!wbm_we_o) rsh <= wbm_dat_i;
            state     <= S_RESP;
          end else if (bus_exp) begin
            wbm_cyc_o <= 1'b0;
            ok        <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= ok ? RSP_OK : RSP_ERR;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            bcnt     <= 2'd0;
            state    <= (ok && !wbm_we_o) ? S_RDATA : S_IDLE;
          end
        end
        S_RDATA: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= rsh[31:24];
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            rsh      <= {rsh[23:0], 8'd0};
            bcnt     <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_byte_master.sv
// Self-checking bench: table of frames plus random frames against a
// protocol-level model, with hand sequences for aborts and stalls.
module tb_wb_byte_master;

  localparam int BT = 8;
  localparam int IT = 20;

  logic        clk = 0;
  logic        wb_rst_i = 1;
  logic [7:0]  rx_data = 0;
  logic        rx_valid = 0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 0;
  logic        wbm_ack_i = 0;
  logic        busy;

  wb_byte_master #(.BUS_TIMEOUT(BT), .IDLE_TIMEOUT(IT)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          dly;
    logic [7:0]  exp_rsp;
    int          exp_stb;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // slave model state
  int          ack_delay = 0;
  logic [31:0] rdata_resp = 0;
  int          stb_cnt = 0;
  int          last_stb_len = 0;
  int          ncycles = 0;
  int          stable_err = 0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  // transmitter model state
  int          ready_mode = 1;
  logic [7:0]  txq[$];
  logic [7:0]  exp_q[$];
  bit          pend = 0;
  logic [7:0]  pend_data;
  int          hold_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (wbm_stb_o) begin
      if (stb_cnt == 0) begin
        cap_adr = wbm_adr_o;
        cap_dat = wbm_dat_o;
        cap_we  = wbm_we_o;
        cap_sel = wbm_sel_o;
        ncycles++;
      end else if (cap_adr !== wbm_adr_o || cap_dat !== wbm_dat_o ||
                   cap_we !== wbm_we_o || wbm_cyc_o !== 1'b1) begin
        stable_err++;
      end
      stb_cnt++;
      wbm_ack_i = (ack_delay >= 0) && (stb_cnt == ack_delay + 1);
      wbm_dat_i = rdata_resp;
    end else begin
      if (stb_cnt != 0) last_stb_len = stb_cnt;
      stb_cnt = 0;
      wbm_ack_i = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend && (!tx_valid || tx_data !== pend_data)) hold_err++;
    case (ready_mode)
      0:       tx_ready = 0;
      1:       tx_ready = 1;
      default: tx_ready = 1'($urandom % 2);
    endcase
    pend      = tx_valid && !tx_ready;
    pend_data = tx_data;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  // protocol-level model: ack within the timeout window means success
  function automatic bit model_ok(input vec_t v);
    return (v.dly >= 0) && (v.dly < BT);
  endfunction

  function automatic int model_stb(input vec_t v);
    return model_ok(v) ? v.dly + 1 : BT;
  endfunction

  task automatic build_exp(input vec_t v);
    exp_q.delete();
    if (!model_ok(v)) begin
      exp_q.push_back(8'h45);
    end else begin
      exp_q.push_back(8'h4B);
      if (!v.wr)
        for (int i = 0; i < 4; i++) exp_q.push_back(v.rdata[31-8*i -: 8]);
    end
  endtask

  task automatic send_frame(input bit wr, input logic [31:0] adr,
                            input logic [31:0] dat);
    logic [7:0] b[$];
    b.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) b.push_back(adr[31-8*i -: 8]);
    if (wr) for (int i = 0; i < 4; i++) b.push_back(dat[31-8*i -: 8]);
    foreach (b[i]) begin
      @(posedge clk); #1;
      rx_valid = 1;
      rx_data  = b[i];
    end
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic wait_idle(input int budget, output int lat);
    bit done = 0;
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (tx_valid && lat < 0) lat = c + 1;
      if (!busy && !tx_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy expected idle within %0d", budget);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n0, lat;
    build_exp(v);
    txq.delete();
    n0 = ncycles;
    hold_err = 0;
    stable_err = 0;
    ack_delay = v.dly;
    rdata_resp = v.rdata;
    send_frame(v.wr, v.adr, v.dat);
    chk("cyc_rise", wbm_cyc_o, 1);
    wait_idle(500, lat);
    if (v.dly == 0) chk("latency", lat, 3);
    chk("ncycles", ncycles - n0, 1);
    chk("adr", cap_adr, v.adr);
    chk("we", cap_we, v.wr);
    chk("sel", cap_sel, 4'hF);
    if (v.wr) chk("wdat", cap_dat, v.dat);
    chk("stb_len", last_stb_len, v.exp_stb);
    chk("rsp_len", txq.size(), exp_q.size());
    if (txq.size() > 0) chk("rsp_status", txq[0], v.exp_rsp);
    for (int i = 1; i < exp_q.size() && i < txq.size(); i++)
      chk("rsp_byte", txq[i], exp_q[i]);
    chk("tx_hold", hold_err, 0);
    chk("bus_stable", stable_err, 0);
  endtask

  vec_t vt[13];

  initial begin
    int n0, lat;
    bit seen;
    vec_t r;

    vt[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0, 2, 8'h4B, 3};
    vt[1] = '{1'b0, 32'h3000_0008, 32'h0, 32'h1234_5678, 0, 8'h4B, 1};
    vt[2] = '{1'b0, 32'h3000_000C, 32'h0, 32'hAAAA_5555, -1, 8'h45, BT};
    vt[3] = '{1'b1, 32'h0000_0010, 32'h0102_0304, 32'h0, BT-1, 8'h4B, BT};
    vt[4] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, BT, 8'h45, BT};
    for (int i = 5; i < 13; i++) begin
      r.wr    = 1'($urandom % 2);
      r.adr   = $urandom;
      r.dat   = $urandom;
      r.rdata = $urandom;
      r.dly   = int'($urandom_range(0, 10));
      if (r.dly == 10) r.dly = -1;
      r.exp_rsp = model_ok(r) ? 8'h4B : 8'h45;
      r.exp_stb = model_stb(r);
      vt[i] = r;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_sel", wbm_sel_o, 4'hF);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_busy", busy, 0);
    wb_rst_i = 0;

    ready_mode = 1;
    run_vec(vt[1]);
    ready_mode = 2;
    foreach (vt[i]) run_vec(vt[i]);

    // unknown command byte is discarded
    n0 = ncycles;
    txq.delete();
    seen = 0;
    @(posedge clk); #1;
    rx_valid = 1;
    rx_data  = 8'h41;
    @(posedge clk); #1;
    rx_valid = 0;
    repeat (6) begin
      if (busy) seen = 1;
      @(posedge clk); #1;
    end
    chk("badcmd_busy", seen, 0);
    chk("badcmd_bus", ncycles - n0, 0);
    chk("badcmd_tx", txq.size(), 0);

    // partial frame followed by silence
    n0 = ncycles;
    foreach (vt[0].adr[i]) begin end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rx_valid = 1;
      rx_data  = (i == 0) ? 8'h52 : ((i == 1) ? 8'h30 : 8'h00);
    end
    @(posedge clk); #1;
    rx_valid = 0;
    chk("abort_busy_mid", busy, 1);
    repeat (2 * IT) @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bus", ncycles - n0, 0);
    chk("abort_tx", txq.size(), 0);
    run_vec(vt[1]);

    // reset while a bus cycle is open
    ready_mode = 1;
    ack_delay = -1;
    txq.delete();
    send_frame(1'b0, 32'h1000_0000, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_stb_pre", wbm_stb_o, 1);
    wb_rst_i = 1;
    @(posedge clk); #1;
    chk("mid_cyc", wbm_cyc_o, 0);
    chk("mid_stb", wbm_stb_o, 0);
    chk("mid_txv", tx_valid, 0);
    chk("mid_busy", busy, 0);
    wb_rst_i = 0;
    run_vec(vt[0]);

    // bytes arriving while the status byte is stalled are dropped
    ready_mode = 0;
    ack_delay = 1;
    txq.delete();
    n0 = ncycles;
    send_frame(1'b1, 32'h2000_0000, 32'h5555_AAAA);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (tx_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("stall_txv", seen, 1);
    send_frame(1'b1, 32'h4000_0000, 32'h1111_2222);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_bus", ncycles - n0, 1);
    chk("stall_txd", tx_data, 8'h4B);
    ready_mode = 1;
    wait_idle(100, lat);
    chk("stall_len", txq.size(), 1);
    if (txq.size() > 0) chk("stall_rsp", txq[0], 8'h4B);
    run_vec(vt[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_byte_master.md
# wb_byte_master

Wishbone initiator driven by a byte stream: decodes read/write command frames from a UART receiver byte interface, runs one classic single Wishbone cycle on the user bus, and returns a status/data frame on a UART transmitter byte interface. It is the bus-master counterpart of the UART Wishbone slave macro. It lets an external host poke user-area registers through the UART pins.

## Interface
- BUS_TIMEOUT, 255: max cycles with stb high and no ack before the cycle is aborted.
- IDLE_TIMEOUT, 100000: max cycles between bytes of one frame before the parser returns to IDLE.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset. The design uses one clock; reset is synchronous and active-high.
- rx_data  in  8  received byte, valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe; there is no backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid; held until it is accepted.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle and strobe; always driven equal.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects; always 4'hF.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  cycle acknowledge.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame format:
  - Write: 0x57 ('W'), 4 address bytes, 4 data bytes. All multi-byte fields are MSB first.
  - Read: 0x52 ('R'), 4 address bytes.
- Response format:
  - Write: 0x4B ('K') on ack, 0x45 ('E') on timeout.
  - Read: 'K' followed by 4 data bytes MSB first, or a single 'E'.
- States and transitions:
  - IDLE: a 'W' or 'R' byte → ADDR and latches we. Any other byte is discarded and the block stays in IDLE.
  - ADDR: shifts 4 bytes into adr using a 2-bit byte counter. On the 4th byte → WDATA if write, else BUS.
  - WDATA: shifts 4 bytes into dat_o. On the 4th byte → BUS.
  - BUS: cyc/stb are high.
    - ack → RESP with status K. For a read, dat_i is captured into the shift register.
    - timeout → RESP with status E.
  - RESP: presents the status byte.
    - Accepted and status is K with a read → RDATA.
    - Otherwise accepted → IDLE.
  - RDATA: presents the 4 captured bytes MSB first, advancing on each accept. After the 4th accept → IDLE.
- Bytes received while in BUS, RESP or RDATA are dropped silently.
- Inter-byte timer:
  - Runs in ADDR and WDATA and clears on every rx_valid.
  - Reaching IDLE_TIMEOUT → IDLE. Partial fields are discarded and no response is sent.
- The bus timer clears on entry to BUS.
- Arithmetic:
  - Timer widths are $clog2(N+1).
  - Counters saturate; they do not wrap.
  - The byte counter wraps 3→0 only on a field transition.

## Timing
- Reset values:
  - wbm_cyc_o/stb_o/we_o = 0, wbm_sel_o = 4'hF, wbm_adr_o/dat_o = 0.
  - tx_valid = 0, tx_data = 0, busy = 0, state = IDLE.
- Bus cycle start:
  - The cycle after the last frame byte's rx_valid, cyc/stb rise.
  - adr, dat and we are already stable in that cycle and remain stable until the cycle ends.
- Bus cycle end:
  - ack is sampled on the rising edge while stb is high; cyc/stb fall the next cycle.
  - An ack arriving while stb is low is ignored.
  - On timeout, cyc/stb fall after exactly BUS_TIMEOUT cycles of stb high.
  - If ack and timeout coincide in the same cycle, ack wins.
- tx_valid rises the cycle after cyc/stb fall.
- tx handshake:
  - tx_data is constant while tx_valid is high and not accepted.
  - After an accept, the next byte (RDATA) is valid in the following cycle. There is one bubble per byte.
- Minimum latency, last rx byte → 'K' valid, with ack returned on the first stb cycle: 3 cycles.
- Reset mid-operation: all state returns to IDLE in one cycle, including an abort of any open bus cycle (cyc drops) and dropping of any pending tx byte.

## Structure
- Shared package holds:
  - Command byte constants: CMD_WR = 8'h57, CMD_RD = 8'h52.
  - Response constants: RSP_OK = 8'h4B, RSP_ERR = 8'h45.
  - The state enum.
- The whole block is one module.
- A small sub-module `wb_byte_timeout` is natural for the two timers. It has parameter N, inputs clear and enable, and output expired. It is instantiated twice.

## Test plan
- Write: 57 30 00 00 04 DE AD BE EF → one cycle with adr=0x30000004, dat=0xDEADBEEF, we=1, sel=F. Ack after 2 cycles → tx 'K'.
- Read: 52 30 00 00 08 with the slave returning 0x12345678 → tx 4B 12 34 56 78. Insert random tx_ready stalls and check that the byte order is unchanged and no byte is duplicated.
- Timeout: read with no ack, BUS_TIMEOUT=8 → stb high exactly 8 cycles, then tx 'E' only.
- Bad command and idle abort:
  - Byte 0x41 → no bus activity, busy stays 0.
  - 'R' plus 2 address bytes, then silence ≥ IDLE_TIMEOUT → IDLE, no response.
  - A following full frame decodes correctly.
- Reset mid-cycle: assert wb_rst_i while stb is high → cyc, stb and tx_valid are 0 the next cycle; a following frame works normally.
- Bytes sent during the RESP stall are dropped: the next frame decodes correctly and the response stream is exactly one 'K'.
